// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared constants for the LC-3 memory/I-O stage
package lc3_pkg;

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

endpackage

// File: rtl/lc3_io_regs.sv
// rtl/lc3_io_regs.sv - LC-3 keyboard/display device registers
module lc3_io_regs
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        io_en,
  input  logic        io_we,
  input  logic [15:0] io_addr,
  input  logic [7:0]  io_wdata,
  output logic [15:0] io_rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  logic       kb_ready_q, kb_ready_d;
  logic [7:0] kbdr_q, kbdr_d;
  logic       ds_ready_q, ds_ready_d;
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_data_q, tx_data_d;

  always_comb begin
    io_rdata = 16'h0000;
    case (io_addr)
      ADDR_KBSR: io_rdata = {kb_ready_q, 15'b0};
      ADDR_KBDR: io_rdata = {8'b0, kbdr_q};
      ADDR_DSR:  io_rdata = {ds_ready_q, 15'b0};
      default:   io_rdata = 16'h0000;
    endcase
  end

  always_comb begin
    kb_ready_d = kb_ready_q;
    kbdr_d     = kbdr_q;
    ds_ready_d = ds_ready_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;

    if (io_en && !io_we && io_addr == ADDR_KBDR) begin
      kb_ready_d = 1'b0;
    end
    // A new byte arriving with a KBDR read leaves the status set.
    if (kb_valid) begin
      kb_ready_d = 1'b1;
      kbdr_d     = kb_data;
    end

    if (tx_valid_q && tx_ready) begin
      tx_valid_d = 1'b0;
      ds_ready_d = 1'b1;
    end
    if (io_en && io_we && io_addr == ADDR_DDR && ds_ready_q) begin
      tx_data_d  = io_wdata;
      tx_valid_d = 1'b1;
      ds_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kb_ready_q <= 1'b0;
      kbdr_q     <= 8'h00;
      ds_ready_q <= 1'b1;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      kb_ready_q <= kb_ready_d;
      kbdr_q     <= kbdr_d;
      ds_ready_q <= ds_ready_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;

endmodule

// File: rtl/lc3_mem_io.sv
// rtl/lc3_mem_io.sv - LC-3 MAR/MDR memory and I/O access stage
module lc3_mem_io
  import lc3_pkg::*;
#(
  parameter int          READ_LATENCY = 1,
  parameter logic [15:0] IO_BASE      = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mio_en,
  input  logic        mem_w_en,
  output logic [15:0] mdr,
  output logic        mem_ready,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  output logic        sram_we,
  output logic        sram_re,
  input  logic [15:0] sram_rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;

  logic        is_io;
  logic        req;
  logic        io_en;
  logic [15:0] io_rdata;

  assign is_io = (mar_q >= IO_BASE);
  // Strobes stay low while reset is held, even with mio_en asserted.
  assign req   = rst && (state_q == ST_IDLE) && mio_en;
  assign io_en = req && is_io;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mar_d   = ld_mar ? bus : mar_q;
    mdr_d   = mdr_q;

    if (ld_mdr && !mio_en) begin
      mdr_d = bus;
    end

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (is_io) begin
            if (!mem_w_en) begin
              mdr_d = io_rdata;
            end
            state_d = ST_DONE;
          end else if (mem_w_en) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          mdr_d   = sram_rdata;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      mar_q   <= 16'h0000;
      mdr_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
    end
  end

  assign mdr        = mdr_q;
  assign mem_ready  = (state_q == ST_DONE);
  assign sram_addr  = mar_q;
  assign sram_wdata = mdr_q;
  assign sram_re    = req && !is_io && !mem_w_en;
  assign sram_we    = req && !is_io && mem_w_en;

  lc3_io_regs u_io_regs (
    .clk      (clk),
    .rst      (rst),
    .io_en    (io_en),
    .io_we    (mem_w_en),
    .io_addr  (mar_q),
    .io_wdata (mdr_q[7:0]),
    .io_rdata (io_rdata),
    .kb_valid (kb_valid),
    .kb_data  (kb_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

endmodule
